// File: rtl/rv_pkg.sv
// Shared register-file write types: widths, LU result payload, write-source tags.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    // One buffered long-latency result waiting for the write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lu_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_BYP  = 2'd3
    } wr_src_e;

endpackage

// File: rtl/rf_sync_fifo.sv
// Small synchronous FIFO holding LU results until the register-file port is free.
module rf_sync_fifo
    import rv_pkg::*;
#(
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_AW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  lu_entry_t         push_data,
    input  logic              pop,
    output lu_entry_t         pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_AW-1:0] count
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_AW-1:0] count_q, count_d;
    lu_entry_t         mem_q [DEPTH];
    lu_entry_t         mem_d [DEPTH];
    logic              push_en;
    logic              pop_en;

    assign full     = (count_q == CNT_AW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer, count and storage updates; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_AW'(1);
            2'b01:   count_d = count_q - CNT_AW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between WB (fixed priority) and buffered LU
// results, and tracks outstanding LU destinations for ID hazard/WAW checks.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_stall,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  chk_hazard,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic [CNT_W-1:0]      conflict_cnt
);

    localparam int unsigned FIFO_CNT_W = $clog2(DEPTH + 1);

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    lu_entry_t             fifo_head;
    lu_entry_t             lu_in;

    wr_src_e               src;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  lu_accept;

    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [XLEN-1:0]       write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]      conflict_cnt_q, conflict_cnt_d;

    assign lu_in = '{rd: lu_rd, data: lu_data};

    rf_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_lu_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (lu_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready depends only on registered occupancy; held low while in reset.
    assign lu_ready     = !fifo_full && !reset;
    assign issue_stall  = pending_q[issue_rd];
    assign chk_hazard   = pending_q[chk_rs1] | pending_q[chk_rs2];
    assign reg_write    = reg_write_q;
    assign write_reg    = write_reg_q;
    assign write_data   = write_data_q;
    assign conflict_cnt = conflict_cnt_q;

    // Port selection: WB, then FIFO head, then LU bypass; x0 writes never win the port.
    always_comb begin
        src       = SRC_NONE;
        sel_rd    = '0;
        sel_data  = '0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        lu_accept = lu_valid && lu_ready;
        if (wb_valid && (wb_rd != '0)) begin
            src      = SRC_WB;
            sel_rd   = wb_rd;
            sel_data = wb_data;
        end else if (!fifo_empty) begin
            src      = SRC_FIFO;
            sel_rd   = fifo_head.rd;
            sel_data = fifo_head.data;
            fifo_pop = 1'b1;
        end else if (lu_accept && (lu_rd != '0)) begin
            src      = SRC_BYP;
            sel_rd   = lu_rd;
            sel_data = lu_data;
        end
        // Accepted LU results not bypassed are buffered; rd=0 results are simply dropped.
        if (lu_accept && (src != SRC_BYP) && (lu_rd != '0)) begin
            fifo_push = 1'b1;
        end
    end

    // Next write-port, scoreboard and conflict-counter values.
    always_comb begin
        reg_write_d    = (src != SRC_NONE);
        write_reg_d    = sel_rd;
        write_data_d   = sel_data;
        pending_d      = pending_q;
        conflict_cnt_d = conflict_cnt_q;
        if ((src == SRC_FIFO) || (src == SRC_BYP)) begin
            pending_d[sel_rd] = 1'b0;
        end
        // Issue applied after retire so a same-cycle set on the same bit wins.
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if ((fifo_count != '0) && (src == SRC_WB) && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // Registered write port, scoreboard and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q    <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            pending_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            reg_write_q    <= reg_write_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            pending_q      <= pending_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

`ifndef SYNTHESIS
    // Issuing onto a pending rd is illegal unless that rd's LU result retires this same cycle.
    logic issue_retires_same_rd;
    assign issue_retires_same_rd = ((src == SRC_FIFO) || (src == SRC_BYP)) && (sel_rd == issue_rd);

    a_no_waw_issue : assert property (@(posedge clk) disable iff (reset)
        !(issue_valid && issue_stall && !issue_retires_same_rd));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        chk_hazard;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [15:0] conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.DEPTH(2), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_stall  (issue_stall),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_hazard   (chk_hazard),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs set beforehand are sampled at it, outputs read 1ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        tick(); tick();
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %0b want 0", reg_write); end
        n_cmp++; if (lu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_in_reset: got %0b want 0", lu_ready); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
            n_bad++; $display("FAIL idle_port: got we=%0b rd=%0d d=%h want 0/0/0", reg_write, write_reg, write_data); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %0b want 1", lu_ready); end
        n_cmp++; if (conflict_cnt !== 16'd0) begin n_bad++; $display("FAIL idle_cnt: got %0d want 0", conflict_cnt); end
        for (int r = 0; r < 32; r++) begin
            chk_rs1 = 5'(r); issue_rd = 5'(r); #1;
            n_cmp++; if (chk_hazard !== 1'b0 || issue_stall !== 1'b0) begin
                n_bad++; $display("FAIL idle_pending[%0d]: got haz=%0b stall=%0b want 0/0", r, chk_hazard, issue_stall); end
        end
        chk_rs1 = '0; issue_rd = '0;
    endtask

    task automatic test_bypass();
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0; chk_rs1 = 5'd5; #1;
        n_cmp++; if (chk_hazard !== 1'b1 || issue_stall !== 1'b1) begin
            n_bad++; $display("FAIL byp_pending_set: got haz=%0b stall=%0b want 1/1", chk_hazard, issue_stall); end
        tick(); tick();
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'h0000_A5A5; #1;
        n_cmp++; if (chk_hazard !== 1'b1) begin n_bad++; $display("FAIL byp_haz_before: got %0b want 1", chk_hazard); end
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'h0000_A5A5) begin
            n_bad++; $display("FAIL byp_write: got we=%0b rd=%0d d=%h want 1/5/0000a5a5", reg_write, write_reg, write_data); end
        n_cmp++; if (chk_hazard !== 1'b0) begin n_bad++; $display("FAIL byp_haz_after: got %0b want 0", chk_hazard); end
        tick();
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL byp_one_cycle: got %0b want 0", reg_write); end
        chk_rs1 = '0; issue_rd = '0;
    endtask

    task automatic test_conflict();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h333;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h11;
        tick();
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h333) begin
            n_bad++; $display("FAIL cf_wb_write: got we=%0b rd=%0d d=%h want 1/3/333", reg_write, write_reg, write_data); end
        lu_rd = 5'd8; lu_data = 32'h22;
        n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL cf_ready_one: got %0b want 1", lu_ready); end
        tick();
        lu_rd = 5'd9; lu_data = 32'h99;
        n_cmp++; if (lu_ready !== 1'b0) begin n_bad++; $display("FAIL cf_ready_full: got %0b want 0", lu_ready); end
        tick(); tick();
        n_cmp++; if (conflict_cnt !== 16'd3) begin n_bad++; $display("FAIL cf_cnt: got %0d want 3", conflict_cnt); end
        n_cmp++; if (write_reg !== 5'd3 || lu_ready !== 1'b0) begin
            n_bad++; $display("FAIL cf_hold: got rd=%0d ready=%0b want 3/0", write_reg, lu_ready); end
        wb_valid = 1'b0;
        tick();
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h11) begin
            n_bad++; $display("FAIL cf_drain7: got we=%0b rd=%0d d=%h want 1/7/11", reg_write, write_reg, write_data); end
        n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL cf_ready_after_pop: got %0b want 1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'h22) begin
            n_bad++; $display("FAIL cf_drain8: got we=%0b rd=%0d d=%h want 1/8/22", reg_write, write_reg, write_data); end
        tick();
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'h99) begin
            n_bad++; $display("FAIL cf_drain9: got we=%0b rd=%0d d=%h want 1/9/99", reg_write, write_reg, write_data); end
        tick();
        n_cmp++; if (reg_write !== 1'b0 || conflict_cnt !== 16'd3) begin
            n_bad++; $display("FAIL cf_idle: got we=%0b cnt=%0d want 0/3", reg_write, conflict_cnt); end
    endtask

    task automatic test_x0();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3A;
        lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
        tick();
        lu_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'hDEAD;
        tick();
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h44) begin
            n_bad++; $display("FAIL x0_wb_drain: got we=%0b rd=%0d d=%h want 1/4/44", reg_write, write_reg, write_data); end
        n_cmp++; if (conflict_cnt !== 16'd3) begin n_bad++; $display("FAIL x0_cnt: got %0d want 3", conflict_cnt); end
        wb_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hBAD;
        n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %0b want 1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL x0_lu_nowrite: got %0b want 0", reg_write); end
        tick();
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL x0_lu_nopush: got %0b want 0", reg_write); end
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick();
        lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h66;
        tick();
        issue_valid = 1'b0; lu_valid = 1'b0; chk_rs2 = 5'd6; #1;
        n_cmp++; if (reg_write !== 1'b1 || write_reg !== 5'd6 || write_data !== 32'h66) begin
            n_bad++; $display("FAIL waw_write: got we=%0b rd=%0d d=%h want 1/6/66", reg_write, write_reg, write_data); end
        n_cmp++; if (chk_hazard !== 1'b1 || issue_stall !== 1'b1) begin
            n_bad++; $display("FAIL waw_set_wins: got haz=%0b stall=%0b want 1/1", chk_hazard, issue_stall); end
        lu_valid = 1'b1; lu_data = 32'h67;
        tick();
        lu_valid = 1'b0;
        n_cmp++; if (chk_hazard !== 1'b0 || issue_stall !== 1'b0) begin
            n_bad++; $display("FAIL waw_clear: got haz=%0b stall=%0b want 0/0", chk_hazard, issue_stall); end
        chk_rs2 = '0; issue_rd = '0;
    endtask

    task automatic test_reset_mid();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h3B;
        lu_valid = 1'b1; lu_rd = 5'd11; lu_data = 32'hB;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_valid = 1'b0; lu_rd = 5'd12; lu_data = 32'hC;
        tick();
        lu_valid = 1'b0; wb_valid = 1'b0; chk_rs1 = 5'd10; #1;
        n_cmp++; if (lu_ready !== 1'b0 || chk_hazard !== 1'b1 || conflict_cnt !== 16'd4) begin
            n_bad++; $display("FAIL rm_before: got ready=%0b haz=%0b cnt=%0d want 0/1/4", lu_ready, chk_hazard, conflict_cnt); end
        reset = 1'b1;
        tick();
        n_cmp++; if (reg_write !== 1'b0 || chk_hazard !== 1'b0 || conflict_cnt !== 16'd0 || lu_ready !== 1'b0) begin
            n_bad++; $display("FAIL rm_in_reset: got we=%0b haz=%0b cnt=%0d ready=%0b want 0/0/0/0",
                              reg_write, chk_hazard, conflict_cnt, lu_ready); end
        reset = 1'b0; #1;
        n_cmp++; if (lu_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready_empty: got %0b want 1", lu_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (reg_write !== 1'b0 || chk_hazard !== 1'b0) begin
                n_bad++; $display("FAIL rm_no_write[%0d]: got we=%0b haz=%0b want 0/0", i, reg_write, chk_hazard); end
        end
        chk_rs1 = '0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_x0();
        test_waw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two sources: the pipeline WB stage and the long-latency unit (LU, e.g. multicycle mul/div or miss-return load).
- WB has fixed priority. LU results wait in a small FIFO until the port is free.
- A 32-entry pending-write scoreboard lets ID stall instructions that read, or overwrite, a register with an outstanding LU result.
- Sits between WB/LU and the register file; drives the register file's reg_write, write_reg and write_data.

Parameters:
- DEPTH, 2, LU result FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB stage has a write this cycle; always accepted, no ready.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- lu_valid  in  1  LU result offered.
- lu_ready  out  1  LU result accepted this cycle when lu_valid && lu_ready.
- lu_rd  in  5  LU destination register.
- lu_data  in  32  LU result.
- issue_valid  in  1  a long-latency op issues to LU this cycle.
- issue_rd  in  5  its destination register.
- issue_stall  out  1  pending[issue_rd]; issuing now would be WAW.
- chk_rs1  in  5  ID source 1.
- chk_rs2  in  5  ID source 2.
- chk_hazard  out  1  pending[chk_rs1] | pending[chk_rs2].
- reg_write  out  1  to register file.
- write_reg  out  5  to register file.
- write_data  out  32  to register file.
- conflict_cnt  out  CNT_W  cycles in which the FIFO was non-empty and wb_valid blocked draining.

Behaviour:
- Reset (reset=1 at a clk edge):
  - reg_write, write_reg, write_data = 0.
  - FIFO empty; pointers and count = 0.
  - pending = 0; conflict_cnt = 0.
  - lu_ready = 0 while reset is high.
- Write-port outputs are registered: a selected write appears on reg_write, write_reg and write_data the cycle after selection, held exactly 1 cycle.
- Selection each cycle, in priority order:
  - (1) wb_valid && wb_rd≠0 → WB.
  - (2) else FIFO non-empty → FIFO head, popped.
  - (3) else lu_valid && lu_rd≠0 → LU bypass; FIFO untouched, counts as the accept.
  - (4) else reg_write=0 next cycle.
- Any write with rd=0 is discarded and never drives reg_write. wb_rd=0 does not block FIFO drain. An accepted LU result with lu_rd=0 is dropped without a FIFO push.
- lu_ready = !full. It is combinational from the registered count only, never from lu_valid or wb_valid.
- FIFO accept: lu_valid && lu_ready and not bypassed → push. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full is impossible because lu_ready=0.
- Ordering: FIFO entries drain in arrival order. Bypass occurs only when the FIFO is empty, so LU results are never reordered.
- Scoreboard, pending[31:0]:
  - Set: issue_valid && issue_rd≠0 sets pending[issue_rd] at the edge.
  - Clear: pending[write_reg] clears at the edge where an LU-sourced write (FIFO or bypass) is selected, i.e. the same edge that loads the output register. From the next cycle chk_hazard reflects this.
  - Same-cycle set and clear of the same bit: set wins.
  - WB-sourced writes never touch pending.
  - pending[0] is always 0.
- chk_hazard and issue_stall are combinational from pending and are valid during reset (0).
- issue_valid while issue_stall=1 is a protocol violation: the bit stays set (no counting) and an assertion fires in simulation.
- ID hazard logic must guarantee that WB and LU never target the same rd while that rd is pending. This block does not resolve that case.
- conflict_cnt increments when count>0 && wb_valid && wb_rd≠0, and saturates at all-ones.
- Reset mid-operation discards FIFO contents and pending bits, with no writes issued.

Decomposition:
- Package rv_pkg:
  - XLEN=32, REG_ADDR_W=5, NUM_REGS=32.
  - typedef lu_entry_t {rd, data}.
  - enum wr_src_e {SRC_NONE, SRC_WB, SRC_FIFO, SRC_BYP}.
- Sub-module rf_sync_fifo (parameterised DEPTH, payload lu_entry_t; push/pop/full/empty/count).
- Arbiter, scoreboard and counter are kept in the top.

Test Plan:
- Reset, then idle 5 cycles → reg_write=0, lu_ready=1, pending=0, conflict_cnt=0.
- Bypass: issue_rd=5; 3 cycles later lu_valid with rd=5, data=0xA5A5 and wb_valid=0 → next cycle reg_write=1, write_reg=5, write_data=0xA5A5. chk_rs1=5 gives chk_hazard=1 until that edge and 0 after.
- Conflict: wb_valid with rd=3 for 4 consecutive cycles; LU offers rd=7 (0x11), rd=8 (0x22), then rd=9 → first two pushed, lu_ready=0 for the third. After WB stops: writes x7=0x11, then x8=0x22, then x9. conflict_cnt=3 (cycles 2–4 of WB).
- x0 handling: wb_valid with rd=0 while the FIFO holds rd=4 → FIFO drains that cycle (x4 written). LU with rd=0 → no reg_write, no push.
- WAW / set-wins: pending[6] clears on the same cycle that issue_rd=6 is issued → pending[6]=1 afterwards, issue_stall=1.
- Reset with 2 FIFO entries and pending[10]=1 → FIFO empty, pending[10]=0, no subsequent reg_write.
